// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the I/D memory port arbiter: FSM state
// encodings, reset polarity and fixed bus constants.
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_D_BUSY  = 3'd1,
        ARB_I_BUSY  = 3'd2,
        ARB_D_DONE  = 3'd3,
        ARB_I_DONE  = 3'd4,
        ARB_I_DRAIN = 3'd5
    } arb_state_t;

    // rst is active-low: this is the level that holds the block in reset
    localparam logic RST_ENABLE = 1'b0;

    // Fetches always read a full word
    localparam logic [3:0] SEL_ALL_BYTES = 4'b1111;

    // Wide enough for the largest supported TIMEOUT (255)
    localparam int TMO_CNT_W = 8;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Busy-cycle counter for the arbiter. Counts while enabled, clears on
// request, and flags the last permitted busy cycle.
module arb_timeout_cnt
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TMO_CNT_W-1:0] LAST = TMO_CNT_W'(TIMEOUT - 1);

    logic [TMO_CNT_W-1:0] cnt;

    // Clear has priority so a finished access always restarts from zero
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Asserted during the final busy cycle the RAM is allowed to answer in
    assign expire = (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter shared by instruction fetch and the memory
// stage. D-side wins ties; each access is a ce/ack handshake with a
// bounded wait that ends in a bus-error pulse.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  IDLE     | bus free, sampling d_ce then i_ce
//  D_BUSY   | D access on the bus, waiting for ack or timeout
//  I_BUSY   | fetch on the bus, waiting for ack or timeout
//  D_DONE   | one cycle, D stall released
//  I_DONE   | one cycle, I stall released
//  I_DRAIN  | flushed fetch still on the bus; result will be dropped
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          d_ce,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [3:0]    d_sel,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    input  logic          i_ce,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    input  logic          flush,
    output logic          stallreq_d,
    output logic          stallreq_i,
    output logic          bus_err,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [3:0]    ram_sel,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    input  logic          ram_ack
);

    arb_state_t state;
    logic       busy;
    logic       expire;

    assign busy = (state == ARB_D_BUSY) || (state == ARB_I_BUSY) ||
                  (state == ARB_I_DRAIN);

    arb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clr    (~busy | ram_ack | expire),
        .en     (busy),
        .expire (expire)
    );

    // Access sequencing; all bus-facing outputs are registered here
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state     <= ARB_IDLE;
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_sel   <= '0;
            ram_wdata <= '0;
            d_rdata   <= '0;
            i_rdata   <= '0;
            bus_err   <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    // flush only blocks fetches; the D request is already masked upstream
                    if (d_ce) begin
                        ram_ce    <= 1'b1;
                        ram_we    <= d_we;
                        ram_addr  <= d_addr;
                        ram_sel   <= d_sel;
                        ram_wdata <= d_wdata;
                        state     <= ARB_D_BUSY;
                    end else if (i_ce && !flush) begin
                        ram_ce    <= 1'b1;
                        ram_we    <= 1'b0;
                        ram_addr  <= i_addr;
                        ram_sel   <= SEL_ALL_BYTES;
                        ram_wdata <= '0;
                        state     <= ARB_I_BUSY;
                    end
                end
                ARB_D_BUSY: begin
                    // flush is ignored: an issued store must complete
                    if (ram_ack || expire) begin
                        ram_ce  <= 1'b0;
                        bus_err <= ~ram_ack;
                        if (!ram_we) begin
                            d_rdata <= ram_ack ? ram_rdata : {DW{1'b1}};
                        end
                        state <= ARB_D_DONE;
                    end
                end
                ARB_I_BUSY: begin
                    if (ram_ack || expire) begin
                        ram_ce  <= 1'b0;
                        bus_err <= ~ram_ack;
                        if (flush) begin
                            state <= ARB_IDLE;
                        end else begin
                            i_rdata <= ram_ack ? ram_rdata : {DW{1'b1}};
                            state   <= ARB_I_DONE;
                        end
                    end else if (flush) begin
                        state <= ARB_I_DRAIN;
                    end
                end
                ARB_I_DRAIN: begin
                    if (ram_ack || expire) begin
                        ram_ce  <= 1'b0;
                        bus_err <= ~ram_ack;
                        state   <= ARB_IDLE;
                    end
                end
                ARB_D_DONE, ARB_I_DONE: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Stalls are gated by reset so every output reads 0 while held in reset
    assign stallreq_d = rst & d_ce & (state != ARB_D_DONE);
    assign stallreq_i = rst & i_ce & (state != ARB_I_DONE) & ~flush;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_ce, d_we, i_ce, flush;
    logic [31:0] d_addr, d_wdata, i_addr;
    logic [3:0]  d_sel;
    logic [31:0] d_rdata, i_rdata;
    logic        stallreq_d, stallreq_i, bus_err;
    logic        ram_ce, ram_we;
    logic [31:0] ram_addr, ram_wdata;
    logic [3:0]  ram_sel;
    logic [31:0] ram_rdata = '0;
    logic        ram_ack = 1'b0;

    mem_port_arbiter #(.DW(32), .AW(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .d_ce(d_ce), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel),
        .d_wdata(d_wdata), .d_rdata(d_rdata),
        .i_ce(i_ce), .i_addr(i_addr), .i_rdata(i_rdata),
        .flush(flush), .stallreq_d(stallreq_d), .stallreq_i(stallreq_i),
        .bus_err(bus_err),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_sel(ram_sel), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } iss_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] ram_mem [256];
    logic [31:0] ref_mem [256];
    int          lat_q [$];
    iss_t        iss_q [$];
    iss_t        cur;
    int          busy_n = 0;
    int          cur_lat = 1;
    logic        prev_ce = 1'b0;
    int          berr_cnt = 0;
    int          ce_cyc = 0;
    int          unstable = 0;
    logic [31:0] exp_d = '0;
    logic [31:0] exp_i = '0;

    // RAM responder and bus monitor. lat = busy cycle that acks (0 = never).
    always @(negedge clk) begin
        if (!rst) begin
            ram_ack = 1'b0;
            prev_ce = 1'b0;
            busy_n  = 0;
        end else begin
            if (bus_err) berr_cnt++;
            if (ram_ce) begin
                ce_cyc++;
                if (!prev_ce) begin
                    busy_n  = 0;
                    cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
                    cur     = '{ram_we, ram_addr, ram_sel, ram_wdata};
                    iss_q.push_back(cur);
                end else if (ram_we !== cur.we || ram_addr !== cur.addr ||
                             ram_sel !== cur.sel || ram_wdata !== cur.wdata) begin
                    unstable++;
                end
                busy_n++;
                ram_ack   = (cur_lat != 0) && (busy_n == cur_lat);
                ram_rdata = ram_mem[ram_addr[9:2]];
                if (ram_ack && ram_we) begin
                    for (int b = 0; b < 4; b++)
                        if (ram_sel[b]) ram_mem[ram_addr[9:2]][8*b +: 8] = ram_wdata[8*b +: 8];
                end
            end else begin
                ram_ack = 1'b0;
            end
            prev_ce = ram_ce;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One pipeline step: hold requests until each side's stall drops, then
    // compare against what the arbitration rules predict.
    task automatic run_txn(input logic hd, input logic dwe, input logic [31:0] da,
                           input logic [3:0] ds, input logic [31:0] dwd, input int dlat,
                           input logic hi, input logic [31:0] ia, input int ilat,
                           input int flush_at);
        int   bd, bi, sd, si, cyc, b0, c0, u0, nexp;
        logic dto, ito, dp, ip;
        logic [31:0] od, oi;
        iss_t e;
        dto = (dlat == 0) || (dlat > TO);
        ito = (ilat == 0) || (ilat > TO);
        bd  = dto ? TO : dlat;
        bi  = ito ? TO : ilat;
        if (hd) lat_q.push_back(dlat);
        if (hi) lat_q.push_back(ilat);
        iss_q.delete();
        b0 = berr_cnt; c0 = ce_cyc; u0 = unstable;
        d_ce = hd; d_we = dwe; d_addr = da; d_sel = ds; d_wdata = dwd;
        i_ce = hi; i_addr = ia;
        dp = hd; ip = hi; sd = 0; si = 0; cyc = 0; od = '0; oi = '0;
        while ((dp || ip) && cyc < 300) begin
            #1;
            if (dp) begin
                if (stallreq_d) sd++; else begin dp = 1'b0; od = d_rdata; end
            end
            if (ip) begin
                if (stallreq_i) si++; else begin ip = 1'b0; oi = i_rdata; end
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (!dp) d_ce = 1'b0;
            if (!ip) i_ce = 1'b0;
            flush = (cyc == flush_at);
        end
        flush = 1'b0; d_ce = 1'b0; i_ce = 1'b0;
        chk("release_within_budget", 32'(dp | ip), 32'd0);
        // reference: D first, D write lands before the I read is issued
        if (hd) begin
            if (dwe && !dto) begin
                for (int b = 0; b < 4; b++)
                    if (ds[b]) ref_mem[da[9:2]][8*b +: 8] = dwd[8*b +: 8];
            end else if (!dwe) begin
                exp_d = dto ? 32'hFFFF_FFFF : ref_mem[da[9:2]];
            end
            chk("d_stall_cycles", 32'(sd), 32'(1 + bd));
            chk("d_rdata", od, exp_d);
        end
        if (hi) begin
            exp_i = ito ? 32'hFFFF_FFFF : ref_mem[ia[9:2]];
            chk("i_stall_cycles", 32'(si), hd ? 32'(bd + bi + 3) : 32'(1 + bi));
            chk("i_rdata", oi, exp_i);
        end
        nexp = (hd ? 1 : 0) + (hi ? 1 : 0);
        chk("issue_count", 32'(iss_q.size()), 32'(nexp));
        if (hd && iss_q.size() > 0) begin
            e = iss_q.pop_front();
            chk("d_bus_addr", e.addr, da);
            chk("d_bus_we", 32'(e.we), 32'(dwe));
            chk("d_bus_sel", 32'(e.sel), 32'(ds));
            if (dwe) chk("d_bus_wdata", e.wdata, dwd);
        end
        if (hi && iss_q.size() > 0) begin
            e = iss_q.pop_front();
            chk("i_bus_addr", e.addr, ia);
            chk("i_bus_we", 32'(e.we), 32'd0);
            chk("i_bus_sel", 32'(e.sel), 32'hF);
        end
        chk("bus_err_pulses", 32'(berr_cnt - b0),
            32'((hd && dto ? 1 : 0) + (hi && ito ? 1 : 0)));
        chk("ram_ce_cycles", 32'(ce_cyc - c0), 32'((hd ? bd : 0) + (hi ? bi : 0)));
        chk("bus_stable", 32'(unstable - u0), 32'd0);
    endtask

    function automatic int rand_lat();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 9) return TO + 4;
        return r;
    endfunction

    initial begin
        logic [31:0] prev_i;
        logic        hd, hi, dwe;
        logic [31:0] da, ia;
        int          fa;

        for (int k = 0; k < 256; k++) begin
            ram_mem[k] = (k * 32'h0101_0101) ^ 32'h5A5A_0000;
            ref_mem[k] = (k * 32'h0101_0101) ^ 32'h5A5A_0000;
        end
        ram_mem[8'h40] = 32'h3C01_1234; ref_mem[8'h40] = 32'h3C01_1234;
        ram_mem[8'h50] = 32'hDEAD_BEEF; ref_mem[8'h50] = 32'hDEAD_BEEF;

        rst = 1'b0; d_ce = 0; d_we = 0; i_ce = 0; flush = 0;
        d_addr = '0; d_sel = '0; d_wdata = '0; i_addr = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ram_ce", 32'(ram_ce), 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // zero-wait fetch
        run_txn(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1, 1'b1, 32'h100, 1, -1);
        // simultaneous D read and fetch, D first
        run_txn(1'b1, 1'b0, 32'h0A8, 4'hF, 32'h0, 2, 1'b1, 32'h0C4, 1, -1);
        // delayed store with a flush pulse mid-access
        run_txn(1'b1, 1'b1, 32'h204, 4'b0011, 32'h0000_ABCD, 5, 1'b0, 32'h0, 1, 2);
        run_txn(1'b1, 1'b0, 32'h204, 4'hF, 32'h0, 1, 1'b0, 32'h0, 1, -1);

        // flushed fetch drains without updating i_rdata
        prev_i = exp_i;
        iss_q.delete();
        lat_q.push_back(3);
        i_ce = 1'b1; i_addr = 32'h140;
        @(posedge clk); @(negedge clk);
        flush = 1'b1;
        #1 chk("flush_masks_stall_i", 32'(stallreq_i), 32'd0);
        @(posedge clk); @(negedge clk);
        flush = 1'b0; i_addr = 32'h180;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        #1;
        chk("drain_keeps_i_rdata", i_rdata, prev_i);
        chk("drain_no_i_done", 32'(stallreq_i), 32'd1);
        chk("drain_ce_dropped", 32'(ram_ce), 32'd0);
        lat_q.push_back(1);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        #1;
        exp_i = ref_mem[8'h60];
        chk("refetch_release", 32'(stallreq_i), 32'd0);
        chk("refetch_i_rdata", i_rdata, exp_i);
        chk("refetch_issue_count", 32'(iss_q.size()), 32'd2);
        if (iss_q.size() == 2) chk("refetch_addr", iss_q[1].addr, 32'h180);
        i_ce = 1'b0;
        @(negedge clk);

        // read that is never answered
        run_txn(1'b1, 1'b0, 32'h300, 4'hF, 32'h0, 0, 1'b0, 32'h0, 1, -1);

        for (int n = 0; n < 30; n++) begin
            hd  = 1'($urandom_range(0, 1));
            hi  = hd ? 1'($urandom_range(0, 1)) : 1'b1;
            dwe = 1'($urandom_range(0, 1));
            da  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            ia  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            fa  = (!hi && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : -1;
            run_txn(hd, dwe, da, 4'($urandom_range(1, 15)), $urandom, rand_lat(),
                    hi, ia, rand_lat(), fa);
        end

        // asynchronous reset in the middle of a store
        lat_q.push_back(0);
        d_ce = 1'b1; d_we = 1'b1; d_addr = 32'h3F0; d_sel = 4'hF; d_wdata = 32'h1234_5678;
        i_ce = 1'b1; i_addr = 32'h10;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        #1 chk("pre_rst_ce", 32'(ram_ce), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_ram_ce", 32'(ram_ce), 32'd0);
        chk("arst_ram_we", 32'(ram_we), 32'd0);
        chk("arst_ram_addr", ram_addr, 32'd0);
        chk("arst_ram_sel", 32'(ram_sel), 32'd0);
        chk("arst_ram_wdata", ram_wdata, 32'd0);
        chk("arst_d_rdata", d_rdata, 32'd0);
        chk("arst_i_rdata", i_rdata, 32'd0);
        chk("arst_stallreq_d", 32'(stallreq_d), 32'd0);
        chk("arst_stallreq_i", 32'(stallreq_i), 32'd0);
        chk("arst_bus_err", 32'(bus_err), 32'd0);
        d_ce = 1'b0; i_ce = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_d = '0; exp_i = '0;
        lat_q.delete();
        @(negedge clk);
        run_txn(1'b1, 1'b0, 32'h3F0, 4'hF, 32'h0, 1, 1'b0, 32'h0, 1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between instruction fetch (I-side) and the memory-access stage (D-side).
- Sequences each access as a ce/ack handshake against a RAM that may take one or more cycles to answer.
- Produces per-side stall requests for the pipeline controller, and a bus-error pulse when the RAM never answers.
- Sits between the IF/MEM stages and the external RAM; the D-side inputs are the final, exception-masked outputs of the memory stage.

Parameters:
- DW, 32, data width.
- AW, 32, address width.
- TIMEOUT, 16, maximum cycles waiting for ram_ack before forced termination (2..255).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- d_ce  in  1  D-side request.
- d_we  in  1  D-side write (1) or read (0).
- d_addr  in  AW  D-side byte address.
- d_sel  in  4  D-side byte enables.
- d_wdata  in  DW  D-side write data.
- d_rdata  out  DW  D-side read data (registered).
- i_ce  in  1  I-side fetch request (always a read, sel 4'b1111).
- i_addr  in  AW  fetch address.
- i_rdata  out  DW  fetched instruction (registered).
- flush  in  1  pipeline flush (exception/eret).
- stallreq_d  out  1  D-side stall request.
- stallreq_i  out  1  I-side stall request.
- bus_err  out  1  one-cycle pulse on timeout.
- ram_ce  out  1  RAM chip enable (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_addr  out  AW  RAM address (registered).
- ram_sel  out  4  RAM byte enables (registered).
- ram_wdata  out  DW  RAM write data (registered).
- ram_rdata  in  DW  RAM read data, valid when ram_ack=1.
- ram_ack  in  1  RAM completion strobe.

Behaviour:
Reset:
- All outputs 0, state IDLE, timeout counter 0.
- A reset mid-transaction drops ram_ce immediately (asynchronous); the in-flight access is abandoned.

States: IDLE, D_BUSY, I_BUSY, D_DONE, I_DONE, I_DRAIN.
- IDLE, d_ce=1: latch the D request onto the ram_* outputs, ram_ce=1, go D_BUSY. D-side has priority because it is the older instruction.
- IDLE, d_ce=0, i_ce=1, flush=0: latch the fetch (ram_we=0, sel 4'b1111), go I_BUSY.
- IDLE, flush=1: no new I request is issued. A D request is still issued (the memory stage has already masked it).
- D_BUSY / I_BUSY: ram_* outputs are held stable. The counter increments each cycle.
- On ram_ack:
  - ram_ce=0.
  - Read: capture ram_rdata into d_rdata or i_rdata.
  - Go D_DONE or I_DONE; counter cleared.
- Counter reaches TIMEOUT-1 without ack:
  - ram_ce=0, bus_err pulses for 1 cycle.
  - The read result is 32'hFFFF_FFFF.
  - Go to the DONE state of that side.
- D_DONE / I_DONE: last exactly 1 cycle, during which that side's stall is released so the pipeline advances; then IDLE.
  - A new request cannot be issued from a DONE state; the minimum spacing between issues is 3 cycles (issue, ack at earliest, done).
- flush during I_BUSY:
  - The bus access is not aborted; go I_DRAIN.
  - On ack or timeout in I_DRAIN: discard the data (i_rdata unchanged), go IDLE with no I_DONE.
- flush during D_BUSY: ignored. An issued store always completes.

Stalls (combinational from state and inputs):
- stallreq_d = d_ce & (state != D_DONE).
- stallreq_i = i_ce & (state != I_DONE) & ~flush.
- stallreq_d=1 implies the pipeline freezes IF as well. The arbiter does not merge the two stalls.

Latency:
- Zero-wait RAM (ack the cycle after ce): 3 cycles from request to release (issue, busy/ack, done).

Other rules:
- The d_*/i_* inputs are sampled only in IDLE. Changes while busy are ignored.
- Address alignment is not checked here; misalignment is handled upstream.

Decomposition:
- Shared defines include: state encodings (3-bit, localparam-style defines `ARB_IDLE etc.), `ZeroWord, `RstEnable-style macros for active-low polarity, and `BusErrWord = 32'hFFFF_FFFF.
- One natural sub-module: arb_timeout_cnt (clear/enable/expire counter parameterised by TIMEOUT).
- All other logic stays flat.

Test Plan:
1. Reset released, d_ce=0, i_ce=1, i_addr=0x100, RAM acks on the next cycle with 0x3C011234 -> ram_ce high for 1 cycle at addr 0x100, sel 1111; i_rdata=0x3C011234; stallreq_i low in I_DONE, 3 cycles total.
2. d_ce=1, d_we=0 and i_ce=1 in the same cycle -> D served first (d_addr on the bus), then I; stallreq_i stays high until I_DONE.
3. Store: d_we=1, d_addr=0x204, d_sel=0011, d_wdata=0xABCD, RAM ack delayed 4 cycles, flush pulsed in cycle 2 -> ram_* held stable for all 5 cycles; write completes; D_DONE reached.
4. Fetch in I_BUSY, flush asserted, ack arrives with 0xDEADBEEF -> i_rdata keeps its previous value; no I_DONE; next state IDLE.
5. Read with ram_ack never asserted, TIMEOUT=16 -> after 16 busy cycles: bus_err pulses once; d_rdata=0xFFFFFFFF; stallreq_d released.
6. rst asserted low mid-D_BUSY -> ram_ce and all outputs go 0 asynchronously (before the next clock edge); state IDLE after release.
